store_lane_packer: RTL and testbench
====================================

// Module: store_lane_packer
// PURPOSE
//  Store-path narrowing unit for the pipelined MIPS data memory: takes a 32-bit register value, access size and byte address from EX/MEM.
//  Produces word-aligned address, lane-replicated write data and byte enables. It is the inverse of the load-side sign/zero extension.
//  Registered, valid/ready handshake toward data memory; 2-entry skid buffer keeps 1 store/cycle under backpressure.
// PARAMETERS
//  AW  32  byte-address width
//  DW  32  data width (fixed 32; BE width DW/8=4)
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  s_valid      in   1   store request valid from EX/MEM
//  s_ready      out  1   packer can accept a request this cycle
//  s_addr       in   AW  byte address
//  s_data       in   DW  rt register value (right-justified)
//  s_size       in   2   00 byte (sb), 01 half (sh), 10 word (sw), 11 reserved
//  m_valid      out  1   packed store valid to data memory
//  m_ready      in   1   data memory accepts store
//  m_addr       out  AW  word-aligned address {s_addr[AW-1:2],2'b00}
//  m_wdata      out  DW  lane-replicated write data
//  m_be         out  4   byte enables, bit i = byte lane i (little-endian)
//  misalign_err out  1   1-cycle pulse: request dropped as misaligned/illegal
//  err_addr     out  AW  byte address of last dropped request
// BEHAVIOUR
//  Reset (rst=1 at edge): m_valid=0, m_addr=0, m_wdata=0, m_be=0, misalign_err=0, err_addr=0, state EMPTY; s_ready=0 while rst=1.
//  Handshake: accept when s_valid&s_ready. Output transfer when m_valid&m_ready. m_* are held stable while m_valid&!m_ready.
//  Latency: accepted request appears on m_* next cycle (1 cycle) if output reg free; order strictly preserved.
//  s_ready = !rst & (state!=FULL), registered-state based, no comb path from m_ready.
//  Packing: byte: wdata={4{d[7:0]}}, be=4'b0001<<a[1:0]
//           half: wdata={2{d[15:0]}}, be=4'b0011<<{a[1],1'b0}
//           word: wdata=d, be=4'b1111
//  FSM (output reg OUT, skid reg SKID):
//   EMPTY: accept -> OUT, go ONE.
//   ONE: accept & out-xfer -> OUT reloaded, stay ONE; accept & !xfer -> SKID, go FULL; xfer only -> EMPTY.
//   FULL (s_ready=0): xfer -> SKID moves to OUT, go ONE; else hold.
//  Simultaneous accept+xfer in ONE: no bubble, m_valid stays 1.
//  Dropped requests (see CONFIGURATION) are accepted (consume s_ready), never reach OUT/SKID, no state change.
//  Reset mid-operation: OUT and SKID contents discarded, no partial write issued.
// CONFIGURATION
//  Macro STORE_MISALIGN_TRAP_EN:
//   defined: half with a[0]=1, word with a[1:0]!=0, or size 11 -> dropped. misalign_err=1 the next cycle; err_addr<=s_addr.
//   undefined: low address bits ignored (half uses a[1], word uses lane 0). Size 11 treated as word. misalign_err and err_addr tied 0.
// STRUCTURE
//  Package mips_mem_pkg: SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD localparams, size_t typedef, state encoding EMPTY/ONE/FULL.
//  Sub-module store_lane_encode (combinational: addr[1:0],size,data -> wdata,be,misaligned), instantiated once before the skid regs.
// TESTING
//  1 sb a=0x1003 d=0x000000A5 m_ready=1 -> next cycle m_addr=0x1000 m_wdata=0xA5A5A5A5 m_be=4'b1000.
//  2 sh a=0x2002 d=0x0000BEEF -> m_wdata=0xBEEFBEEF m_be=4'b1100; sw a=0x2004 d=0x12345678 -> be=4'b1111.
//  3 backpressure: m_ready=0, issue 3 back-to-back sw -> s_ready=0 after 2nd accept. Release m_ready -> 3 stores emitted in order, none lost or duplicated.
//  4 streaming: m_ready=1, 8 consecutive stores -> m_valid continuously 1 from cycle 2, one output per cycle.
//  5 TRAP_EN: sw a=0x3001 -> no m_valid, misalign_err pulse, err_addr=0x3001. Without macro: m_addr=0x3000 m_be=4'b1111.
//  6 rst asserted with OUT+SKID full -> next cycle m_valid=0 m_be=0, s_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory store path: access sizes and
// the skid-buffer state of store_lane_packer.
package mips_mem_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;
  localparam size_t SZ_RSVD = 2'b11;

  // ONE: output register holds a store; FULL: skid register holds one too
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

endpackage

// File: rtl/store_lane_encode.sv
// Combinational lane steering for sb/sh/sw: replicates the store data across
// lanes and builds byte enables. Misalignment flagged only with STORE_MISALIGN_TRAP_EN.
module store_lane_encode
  import mips_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_t       size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  always_comb begin
    wdata      = data;
    be         = 4'b1111;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata = {2{data[15:0]}};
        be    = 4'b0011 << {addr_lo[1], 1'b0};
`ifdef STORE_MISALIGN_TRAP_EN
        misaligned = addr_lo[0];
`endif
      end
      // Word, and the reserved size which is a plain word without the trap
      default: begin
`ifdef STORE_MISALIGN_TRAP_EN
        misaligned = (size == SZ_RSVD) || (addr_lo != 2'b00);
`endif
      end
    endcase
  end

endmodule

// File: rtl/store_lane_packer.sv
// Store-path narrowing unit: registered valid/ready stage with a 2-entry skid
// buffer toward data memory. Optional misaligned-store trap: STORE_MISALIGN_TRAP_EN.
module store_lane_packer
  import mips_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_data,
  input  logic [1:0]    s_size,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    m_be,
  output logic          misalign_err,
  output logic [AW-1:0] err_addr
);

  state_t state, next_state;

  logic [AW-1:0] out_addr, skid_addr, in_addr;
  logic [DW-1:0] out_wdata, skid_wdata, in_wdata;
  logic [3:0]    out_be, skid_be, in_be;
  logic          misaligned, accept, drop, push, xfer;
  logic          load_out_in, load_out_skid, load_skid;

  store_lane_encode u_encode (
    .addr_lo    (s_addr[1:0]),
    .size       (size_t'(s_size)),
    .data       (s_data),
    .wdata      (in_wdata),
    .be         (in_be),
    .misaligned (misaligned)
  );

  assign in_addr = {s_addr[AW-1:2], 2'b00};
  assign s_ready = !rst && (state != FULL);
  assign accept  = s_valid && s_ready;
  assign drop    = accept && misaligned;
  assign push    = accept && !misaligned;
  assign m_valid = (state != EMPTY);
  assign xfer    = m_valid && m_ready;
  assign m_addr  = out_addr;
  assign m_wdata = out_wdata;
  assign m_be    = out_be;

  always_comb begin
    next_state    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_out_in = 1'b1;
          next_state  = ONE;
        end
      end
      ONE: begin
        if (push && xfer) begin
          load_out_in = 1'b1;
        end else if (push) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (xfer) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          load_out_skid = 1'b1;
          next_state    = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_addr   <= '0;
      out_wdata  <= '0;
      out_be     <= '0;
      skid_addr  <= '0;
      skid_wdata <= '0;
      skid_be    <= '0;
    end else begin
      state <= next_state;
      if (load_out_in) begin
        out_addr  <= in_addr;
        out_wdata <= in_wdata;
        out_be    <= in_be;
      end else if (load_out_skid) begin
        out_addr  <= skid_addr;
        out_wdata <= skid_wdata;
        out_be    <= skid_be;
      end
      if (load_skid) begin
        skid_addr  <= in_addr;
        skid_wdata <= in_wdata;
        skid_be    <= in_be;
      end
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      misalign_err <= drop;
      if (drop) err_addr <= s_addr;
    end
  end
`else
  assign misalign_err = 1'b0;
  assign err_addr     = '0;
`endif

endmodule

// File: tb/tb_store_lane_packer.sv
// Scoreboard bench for store_lane_packer: stimulus pushes hand-computed
// packed stores, a monitor pops and compares on every output transfer.
module tb_store_lane_packer;

  logic        clk, rst, s_valid, s_ready, m_valid, m_ready, misalign_err;
  logic [31:0] s_addr, s_data, m_addr, m_wdata, err_addr;
  logic [1:0]  s_size;
  logic [3:0]  m_be;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int expected_outputs = 0;
  int seen_outputs = 0;

  store_lane_packer #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_data(s_data), .s_size(s_size),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .misalign_err(misalign_err),
    .err_addr(err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Presents one request and returns one cycle after it is accepted, s_valid still high
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input logic [31:0] e_addr,
                               input logic [31:0] e_wdata, input logic [3:0] e_be,
                               input bit e_drop);
    bit taken = 0;
    s_valid = 1'b1;
    s_addr  = addr;
    s_data  = data;
    s_size  = size;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_ready) begin
        taken = 1;
        if (!e_drop) begin
          sb.push_back('{addr: e_addr, wdata: e_wdata, be: e_be});
          expected_outputs++;
        end
        break;
      end
    end
    if (!taken) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        seen_outputs++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", m_addr, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("m_addr", m_addr, e.addr);
          checkOutput("m_wdata", m_wdata, e.wdata);
          checkOutput("m_be", {28'd0, m_be}, {28'd0, e.be});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0; s_size = '0; m_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_addr", m_addr, 32'd0);
    checkOutput("rst_m_wdata", m_wdata, 32'd0);
    checkOutput("rst_m_be", {28'd0, m_be}, 32'd0);
    checkOutput("rst_misalign_err", {31'd0, misalign_err}, 32'd0);
    checkOutput("rst_err_addr", err_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;

    // Basic packing across sizes and lanes
    applyStimulus(32'h1003, 32'h0000_00A5, 2'b00, 32'h1000, 32'hA5A5_A5A5, 4'b1000, 0);
    checkOutput("sb_m_valid", {31'd0, m_valid}, 32'd1);
    idle();
    applyStimulus(32'h1000, 32'h1234_5611, 2'b00, 32'h1000, 32'h1111_1111, 4'b0001, 0);
    applyStimulus(32'h1001, 32'h1234_5677, 2'b00, 32'h1000, 32'h7777_7777, 4'b0010, 0);
    applyStimulus(32'h2002, 32'h0000_BEEF, 2'b01, 32'h2000, 32'hBEEF_BEEF, 4'b1100, 0);
    applyStimulus(32'h2000, 32'hFFFF_1234, 2'b01, 32'h2000, 32'h1234_1234, 4'b0011, 0);
    applyStimulus(32'h2004, 32'h1234_5678, 2'b10, 32'h2004, 32'h1234_5678, 4'b1111, 0);
    idle();
    idle();

    // Backpressure: two accepted, third waits until the skid drains
    m_ready = 1'b0;
    applyStimulus(32'h5000, 32'hAAAA_0001, 2'b10, 32'h5000, 32'hAAAA_0001, 4'b1111, 0);
    applyStimulus(32'h5004, 32'hAAAA_0002, 2'b10, 32'h5004, 32'hAAAA_0002, 4'b1111, 0);
    @(negedge clk);
    checkOutput("bp_s_ready_full", {31'd0, s_ready}, 32'd0);
    checkOutput("bp_m_addr_held", m_addr, 32'h5000);
    @(posedge clk); #1;
    m_ready = 1'b1;
    applyStimulus(32'h5008, 32'hAAAA_0003, 2'b10, 32'h5008, 32'hAAAA_0003, 4'b1111, 0);
    idle();
    repeat (3) idle();

    // Streaming: one store per cycle, no bubbles
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h4000 + 32'(i * 4), 32'h1000_0000 + 32'(i), 2'b10,
                    32'h4000 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'b1111, 0);
      checkOutput("stream_m_valid", {31'd0, m_valid}, 32'd1);
    end
    idle();
    checkOutput("stream_drained", {31'd0, m_valid}, 32'd0);

`ifdef STORE_MISALIGN_TRAP_EN
    applyStimulus(32'h3001, 32'hDEAD_BEEF, 2'b10, 32'h0, 32'h0, 4'b0000, 1);
    checkOutput("trap_err_pulse", {31'd0, misalign_err}, 32'd1);
    checkOutput("trap_err_addr", err_addr, 32'h3001);
    checkOutput("trap_no_m_valid", {31'd0, m_valid}, 32'd0);
    idle();
    checkOutput("trap_err_clear", {31'd0, misalign_err}, 32'd0);
    applyStimulus(32'h3003, 32'h0000_CAFE, 2'b01, 32'h0, 32'h0, 4'b0000, 1);
    checkOutput("trap_half_err_addr", err_addr, 32'h3003);
    applyStimulus(32'h3008, 32'h0000_0042, 2'b11, 32'h0, 32'h0, 4'b0000, 1);
    checkOutput("trap_rsvd_err", {31'd0, misalign_err}, 32'd1);
    checkOutput("trap_rsvd_no_valid", {31'd0, m_valid}, 32'd0);
    idle();
`else
    applyStimulus(32'h3001, 32'hDEAD_BEEF, 2'b10, 32'h3000, 32'hDEAD_BEEF, 4'b1111, 0);
    checkOutput("noTrap_err", {31'd0, misalign_err}, 32'd0);
    applyStimulus(32'h3003, 32'h0000_CAFE, 2'b01, 32'h3000, 32'hCAFE_CAFE, 4'b1100, 0);
    applyStimulus(32'h3008, 32'h0000_0042, 2'b11, 32'h3008, 32'h0000_0042, 4'b1111, 0);
    idle();
    checkOutput("noTrap_err_addr", err_addr, 32'd0);
`endif
    repeat (2) idle();

    // Reset with OUT and SKID both occupied discards them
    m_ready = 1'b0;
    applyStimulus(32'h6000, 32'h6666_0001, 2'b10, 32'h6000, 32'h6666_0001, 4'b1111, 0);
    applyStimulus(32'h6004, 32'h6666_0002, 2'b10, 32'h6004, 32'h6666_0002, 4'b1111, 0);
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("full_before_rst", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    expected_outputs -= sb.size();
    sb.delete();
    @(negedge clk);
    checkOutput("rst_mid_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_mid_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_mid_m_be", {28'd0, m_be}, 32'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_s_ready_after", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    applyStimulus(32'h7002, 32'h0000_00C3, 2'b00, 32'h7000, 32'hC3C3_C3C3, 4'b0100, 0);
    idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("sb_empty", sb.size(), 32'd0);
    checkOutput("output_count", seen_outputs, expected_outputs);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
